// File: rtl/demux_pkg.sv
// Shared types and constants for the demux_buffer block.
package demux_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned DEFAULT_DEPTH = 2;
    localparam int unsigned STAT_W        = 16;

endpackage

// File: rtl/demux_buffer_if.sv
// Input and dual-output valid/ready bus of demux_buffer.
interface demux_buffer_if
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(word_t)
);
    logic [WIDTH-1:0] inp;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2;
    logic             out2_valid;
    logic             out2_ready;

    modport master (
        output inp, sel, in_valid, out1_ready, out2_ready,
        input  in_ready, out1, out1_valid, out2, out2_valid
    );

    modport slave (
        input  inp, sel, in_valid, out1_ready, out2_ready,
        output in_ready, out1, out1_valid, out2, out2_valid
    );
endinterface

// File: rtl/demux_fifo.sv
// Synchronous valid/ready FIFO; DEPTH must be a power of two, at least 2.
module demux_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Full blocks pushes even when a pop happens on the same edge.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/demux_buffer.sv
// Routes each input word to one of two buffered outputs selected by sel.
// Optional per-destination accept counters under `DEMUX_BUFFER_STATS_EN.
module demux_buffer
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(word_t),
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    demux_buffer_if.slave    bus
`ifdef DEMUX_BUFFER_STATS_EN
    ,
    output logic [STAT_W-1:0] cnt1,
    output logic [STAT_W-1:0] cnt2
`endif
);
    logic ready1;
    logic ready2;

    // sel=1 targets out1, sel=0 targets out2; in_ready ignores in_valid.
    assign bus.in_ready = bus.sel ? ready1 : ready2;

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.in_valid && bus.sel),
        .in_ready  (ready1),
        .in_data   (bus.inp),
        .out_valid (bus.out1_valid),
        .out_ready (bus.out1_ready),
        .out_data  (bus.out1)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.in_valid && !bus.sel),
        .in_ready  (ready2),
        .in_data   (bus.inp),
        .out_valid (bus.out2_valid),
        .out_ready (bus.out2_ready),
        .out_data  (bus.out2)
    );

`ifdef DEMUX_BUFFER_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic acc1;
    logic acc2;

    assign acc1 = bus.in_valid && bus.sel  && ready1;
    assign acc2 = bus.in_valid && !bus.sel && ready2;

    // Saturating accept counters per destination.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (acc1 && (cnt1 != STAT_MAX)) cnt1 <= cnt1 + STAT_W'(1);
            if (acc2 && (cnt2 != STAT_MAX)) cnt2 <= cnt2 + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux_buffer.sv
// Self-checking bench for demux_buffer: vector table plus per-destination scoreboard.
module tb_demux_buffer;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        sel;
        logic        valid;
        logic        r1;
        logic        r2;
        logic        rdy;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    demux_buffer_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_BUFFER_STATS_EN
    logic [15:0] cnt1;
    logic [15:0] cnt2;
`endif

    demux_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DEMUX_BUFFER_STATS_EN
        ,
        .cnt1  (cnt1),
        .cnt2  (cnt2)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the scoreboard model, then advance the model.
    task automatic score();
        logic exp_rdy;
        chk("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
        if (q1.size() != 0) chk("out1", bus.out1, q1[0]);
        chk("out2_valid", 32'(bus.out2_valid), 32'(q2.size() != 0));
        if (q2.size() != 0) chk("out2", bus.out2, q2[0]);
        exp_rdy = bus.sel ? (q1.size() < DEPTH) : (q2.size() < DEPTH);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (q1.size() != 0 && bus.out1_ready) void'(q1.pop_front());
        if (q2.size() != 0 && bus.out2_ready) void'(q2.pop_front());
        if (bus.in_valid && exp_rdy) begin
            if (bus.sel) q1.push_back(bus.inp);
            else         q2.push_back(bus.inp);
        end
    endtask

    task automatic cycle(input vec_t v, input bit use_rdy);
        bus.inp        = v.data;
        bus.sel        = v.sel;
        bus.in_valid   = v.valid;
        bus.out1_ready = v.r1;
        bus.out2_ready = v.r2;
        @(negedge clk);
        if (use_rdy) chk("tbl_in_ready", 32'(bus.in_ready), 32'(v.rdy));
        score();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // data, sel, valid, r1, r2, expected in_ready
        tbl[0]  = '{32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{32'h1,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{32'h2,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{32'h3,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{32'h4,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{32'h5,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{32'h6,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{32'h7,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{32'hCAFE,     1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        reset          = 1'b1;
        bus.inp        = '0;
        bus.sel        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out1_valid", 32'(bus.out1_valid), 32'h0);
        chk("rst_out2_valid", 32'(bus.out2_valid), 32'h0);
        chk("rst_out1", bus.out1, 32'h0);
        chk("rst_out2", bus.out2, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        bus.sel = 1'b0;
        #1;
        chk("rst_in_ready_sel0", 32'(bus.in_ready), 32'h1);
        bus.sel = 1'b1;
        #1;
        chk("rst_in_ready_sel1", 32'(bus.in_ready), 32'h1);
`ifdef DEMUX_BUFFER_STATS_EN
        chk("rst_cnt1", 32'(cnt1), 32'h0);
        chk("rst_cnt2", 32'(cnt2), 32'h0);
`endif
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) cycle(tbl[i], 1'b1);

        // Push and pop on the same edge keeps occupancy at one.
        cycle('{32'hA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}, 1'b1);
        cycle('{32'hB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}, 1'b1);
        chk("simul_count", 32'(dut.u_fifo1.count), 32'h1);
        cycle('{32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}, 1'b1);
        cycle('{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}, 1'b1);
        cycle('{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}, 1'b1);

        // Fill both FIFOs, then reset between edges.
        cycle('{32'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}, 1'b1);
        cycle('{32'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}, 1'b1);
        cycle('{32'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, 1'b1);
        cycle('{32'h44, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, 1'b1);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out1_valid", 32'(bus.out1_valid), 32'h0);
        chk("midrst_out2_valid", 32'(bus.out2_valid), 32'h0);
        chk("midrst_out1", bus.out1, 32'h0);
        chk("midrst_out2", bus.out2, 32'h0);
        q1.delete();
        q2.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle('{32'h0, 1'(i), 1'b0, 1'b1, 1'b1, 1'b1}, 1'b1);

`ifdef DEMUX_BUFFER_STATS_EN
        chk("midrst_cnt1", 32'(cnt1), 32'h0);
        for (int i = 0; i < 3; i++) cycle('{32'(100 + i), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}, 1'b1);
        cycle('{32'h200, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}, 1'b1);
        chk("stats_cnt1", 32'(cnt1), 32'h3);
        chk("stats_cnt2", 32'(cnt2), 32'h1);
        for (int i = 0; i < 65532; i++) cycle('{32'(i), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}, 1'b0);
        chk("stats_cnt1_max", 32'(cnt1), 32'hFFFF);
        cycle('{32'h5A5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}, 1'b1);
        chk("stats_cnt1_sat", 32'(cnt1), 32'hFFFF);
        chk("stats_cnt2_hold", 32'(cnt2), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
